// File: rtl/store_merge_unit.sv
// store_merge_unit: narrows a register value and commits it to word memory,
// using read-modify-write for byte and halfword stores.
module store_merge_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [1:0]  size_q, off_q;
    logic        bad;
    logic [31:0] mask, ins;
    assign bad  = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    // mem_wdata holds the raw register value until WAIT replaces it with the merged word
    assign mask = size_q == 2'b00 ? 32'hff << {off_q, 3'b000} : 32'hffff << {off_q[1], 4'b0000};
    assign ins  = size_q == 2'b00 ? {4{mem_wdata[7:0]}} : {2{mem_wdata[15:0]}};
    assign busy   = state != IDLE;
    assign done   = state == DONE || state == ERR;
    assign err    = state == ERR;
    assign mem_re = state == READ;
    assign mem_we = state == WRITE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = bad ? ERR : (size == 2'b10 ? WRITE : READ);
            READ:    state_nx = WAIT;
            WAIT:    state_nx = WRITE;
            WRITE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                size_q    <= size;
                off_q     <= addr[1:0];
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata;
            end
            if (state == WAIT) mem_wdata <= (mem_rdata & ~mask) | (ins & mask);
        end
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: randomized stores against a reference memory image,
// plus directed alignment, busy, back-to-back and reset cases.
module tb_store_merge_unit;
    logic        clk = 0, rst = 1, start = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
    logic        busy, done, err, mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int n_checks = 0, n_fail = 0, nwe = 0, nre = 0, ndone = 0, nboth = 0;

    store_merge_unit dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        nwe   <= nwe + int'(mem_we);
        nre   <= nre + int'(mem_re);
        ndone <= ndone + int'(done);
        nboth <= nboth + int'(mem_re && mem_we);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input bit poke);
        logic [31:0] exp;
        int idx, w0, r0, d0;
        bit bad;
        idx = int'(a[9:2]);
        bad = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp = ref_mem[idx];
        if (sz == 2'b00) exp[8*a[1:0] +: 8] = wd[7:0];
        else if (sz == 2'b01) exp[16*a[1] +: 16] = wd[15:0];
        else exp = wd;
        w0 = nwe; r0 = nre; d0 = ndone;
        start = 1; size = sz; addr = a; wdata = wd;
        tick();
        start = 0;
        if (bad) begin
            check("err_cycle", {27'd0, busy, done, err, mem_re, mem_we}, 32'b11100);
        end else if (sz == 2'b10) begin
            check("word_write", {27'd0, busy, done, err, mem_re, mem_we}, 32'b10001);
            check("word_addr", mem_addr, {a[31:2], 2'b00});
            check("word_wdata", mem_wdata, exp);
            tick();
            check("word_done", {27'd0, busy, done, err, mem_re, mem_we}, 32'b11000);
        end else begin
            check("rmw_read", {27'd0, busy, done, err, mem_re, mem_we}, 32'b10010);
            check("rmw_addr", mem_addr, {a[31:2], 2'b00});
            if (poke) begin start = 1; addr = $urandom; size = 2'($urandom); end
            tick();
            check("rmw_wait", {27'd0, busy, done, err, mem_re, mem_we}, 32'b10000);
            tick();
            start = 0;
            check("rmw_write", {27'd0, busy, done, err, mem_re, mem_we}, 32'b10001);
            check("rmw_wdata", mem_wdata, exp);
            check("rmw_addr_hold", mem_addr, {a[31:2], 2'b00});
            if (poke) start = 1;
            tick();
            check("rmw_done", {27'd0, busy, done, err, mem_re, mem_we}, 32'b11000);
        end
        tick();
        start = 0;
        check("idle_after", {31'd0, busy}, 32'd0);
        check("write_count", nwe - w0, bad ? 0 : 1);
        check("read_count", nre - r0, (bad || sz == 2'b10) ? 0 : 1);
        check("done_count", ndone - d0, 1);
        if (!bad) ref_mem[idx] = exp;
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int w0, d0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[64] = 32'h11223344;
        ref_mem[64] = 32'h11223344;
        tick();
        tick();
        check("reset_ctl", {27'd0, busy, done, err, mem_re, mem_we}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        rst = 0;
        tick();
        store(2'b00, 32'h101, 32'h000000AB, 0);
        check("byte_plan", mem[64], 32'h1122AB44);
        mem[64] = 32'h11223344;
        ref_mem[64] = 32'h11223344;
        store(2'b01, 32'h102, 32'h0000BEEF, 0);
        check("half_hi_plan", mem[64], 32'hBEEF3344);
        mem[64] = 32'h11223344;
        ref_mem[64] = 32'h11223344;
        store(2'b01, 32'h100, 32'h0000BEEF, 0);
        check("half_lo_plan", mem[64], 32'h1122BEEF);
        store(2'b10, 32'h104, 32'hDEADBEEF, 0);
        check("word_plan", mem[65], 32'hDEADBEEF);
        store(2'b01, 32'h103, 32'h12345678, 0);
        store(2'b10, 32'h102, 32'h12345678, 0);
        store(2'b11, 32'h100, 32'h12345678, 0);
        store(2'b00, 32'h203, 32'hFFFFFF5A, 1);
        store(2'b01, 32'h3FE, 32'h9876C3C3, 1);
        // reset during WAIT aborts the write and the done pulse
        w0 = nwe; d0 = ndone;
        start = 1; size = 2'b00; addr = 32'h102; wdata = 32'h77;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("abort_ctl", {27'd0, busy, done, err, mem_re, mem_we}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        tick();
        tick();
        tick();
        check("abort_no_write", nwe - w0, 0);
        check("abort_no_done", ndone - d0, 0);
        check("abort_mem", mem[64], ref_mem[64]);
        // reset and start on the same edge drop the request
        rst = 1; start = 1; size = 2'b10; addr = 32'h108; wdata = 32'hCAFEF00D;
        tick();
        rst = 0; start = 0;
        tick();
        tick();
        check("rst_start_idle", {31'd0, busy}, 32'd0);
        check("rst_start_no_write", nwe - w0, 0);
        store(2'b00, 32'h102, 32'h77, 0);
        for (int i = 0; i < 300; i++)
            store(2'($urandom), {22'($urandom), 10'($urandom)}, $urandom, 1'($urandom));
        check("re_we_exclusive", nboth, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
